mandel_scan_ctrl: RTL and testbench

//  Parametrised frame-scan controller for the Mandelbrot engine. Owns the pixel counters
//  (px, py) and the iteration counter (n). Drives init/enable strobes to the external
//  x/y/a/b datapath registers. Emits one pixel (px, py, pn) per point over a valid/ready

---
 rtl/mandel_scan_if.sv | 23 ++
 rtl/mandel_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_mandel_scan_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mandel_scan_if.sv
// Handshake/strobe bundle between the frame-scan controller and the datapath and pixel writer.
interface mandel_scan_if #(
  parameter int XW     = 8,
  parameter int YW     = 7,
  parameter int ITER_W = 8
);
  logic              start, abort, escape, pix_ready;
  logic [ITER_W-1:0] max_iter;
  logic              inity, eny, initx, enx, initab, enab;
  logic [XW-1:0]     px;
  logic [YW-1:0]     py;
  logic [ITER_W-1:0] pn;
  logic              pix_valid, busy, done;

  modport slave (
    input  start, abort, max_iter, escape, pix_ready,
    output inity, eny, initx, enx, initab, enab, px, py, pn, pix_valid, busy, done
  );
  modport master (
    output start, abort, max_iter, escape, pix_ready,
    input  inity, eny, initx, enx, initab, enab, px, py, pn, pix_valid, busy, done
  );
endinterface

// File: rtl/mandel_scan_ctrl.sv
// Mandelbrot frame-scan controller: raster pixel/iteration counters, datapath strobes,
// valid/ready pixel output, runtime max-iteration, abort and restart-after-done.
module mandel_scan_ctrl #(
  parameter int XRES   = 160,
  parameter int YRES   = 120,
  parameter int ITER_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  mandel_scan_if.slave  bus
);
  localparam int XW = $clog2(XRES);
  localparam int YW = $clog2(YRES);
  localparam logic [XW-1:0] X_LAST = XW'(XRES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(YRES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ROW, S_PIXEL, S_ITER, S_EMIT, S_NEXTROW, S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [XW-1:0]     r_px;
  logic [YW-1:0]     r_py;
  logic [ITER_W-1:0] r_n, r_max;
  logic w_inity, w_eny, w_initx, w_enx, w_initab, w_enab, w_valid, w_busy, w_done, w_start_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_inity     = 1'b0;
    w_eny       = 1'b0;
    w_initx     = 1'b0;
    w_enx       = 1'b0;
    w_initab    = 1'b0;
    w_enab      = 1'b0;
    w_valid     = 1'b0;
    w_done      = 1'b0;
    w_start_acc = 1'b0;
    w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    case (r_state)
      S_IDLE, S_DONE: begin
        w_done = (r_state == S_DONE);
        if (bus.start) begin
          w_start_acc = 1'b1;
          w_next      = S_INIT;
        end
      end
      S_INIT: begin
        w_inity = 1'b1;
        w_eny   = 1'b1;
        w_next  = S_ROW;
      end
      S_ROW: begin
        w_initx = 1'b1;
        w_enx   = 1'b1;
        w_next  = S_PIXEL;
      end
      S_PIXEL: begin
        w_initab = 1'b1;
        w_enab   = 1'b1;
        w_next   = S_ITER;
      end
      S_ITER: begin
        // escape and the limit both stop the pixel with n frozen at its current count
        if (bus.escape || (r_n == r_max)) w_next = S_EMIT;
        else                              w_enab = 1'b1;
      end
      S_EMIT: begin
        w_valid = 1'b1;
        if (bus.pix_ready) begin
          if (r_px == X_LAST) w_next = S_NEXTROW;
          else begin
            w_enx  = 1'b1;
            w_next = S_PIXEL;
          end
        end
      end
      S_NEXTROW: begin
        if (r_py == Y_LAST) w_next = S_DONE;
        else begin
          w_eny  = 1'b1;
          w_next = S_ROW;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // abort squashes every strobe and the pixel offer in the same cycle
    if (bus.abort && w_busy) begin
      w_next   = S_IDLE;
      w_inity  = 1'b0;
      w_eny    = 1'b0;
      w_initx  = 1'b0;
      w_enx    = 1'b0;
      w_initab = 1'b0;
      w_enab   = 1'b0;
      w_valid  = 1'b0;
    end
  end

  // counters are driven off the gated strobes, so an aborted cycle leaves them untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px  <= '0;
      r_py  <= '0;
      r_n   <= '0;
      r_max <= '0;
    end else begin
      if (w_start_acc) r_max <= bus.max_iter;
      if (w_inity)     r_py  <= '0;
      else if (w_eny)  r_py  <= r_py + 1'b1;
      if (w_initx)     r_px  <= '0;
      else if (w_enx)  r_px  <= r_px + 1'b1;
      if (w_initab)    r_n   <= '0;
      else if (w_enab) r_n   <= r_n + 1'b1;
    end
  end

  assign bus.inity     = w_inity;
  assign bus.eny       = w_eny;
  assign bus.initx     = w_initx;
  assign bus.enx       = w_enx;
  assign bus.initab    = w_initab;
  assign bus.enab      = w_enab;
  assign bus.px        = r_px;
  assign bus.py        = r_py;
  assign bus.pn        = r_n;
  assign bus.pix_valid = w_valid;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Bench for mandel_scan_ctrl on a 4x2 frame: table of frames plus stall/abort/reset sequences,
// pixels checked against a scoreboard queue filled when each frame is started.
module tb_mandel_scan_ctrl;
  localparam int XRES = 4, YRES = 2, ITER_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mandel_scan_if #(.XW(2), .YW(1), .ITER_W(ITER_W)) bus();
  mandel_scan_ctrl #(.XRES(XRES), .YRES(YRES), .ITER_W(ITER_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int px; int py; int pn; } pix_t;
  typedef struct { int max; int esc_en; int ex; int ey; int eat; int cyc; } frame_t;

  pix_t   sb[$];
  frame_t tbl[5];
  int n_vec = 0, n_err = 0;
  int esc_en = 0, esc_x = 0, esc_y = 0, esc_at = 0, it_cyc = 0;

  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // datapath model: escape raised on a chosen ITER cycle of a chosen pixel
  always @(negedge clk) begin
    if (rst) begin
      it_cyc = 0;
      bus.escape = 1'b0;
    end else begin
      if (bus.initab) it_cyc = 0;
      else            it_cyc++;
      bus.escape = (esc_en != 0) && (int'(bus.px) == esc_x) && (int'(bus.py) == esc_y) && (it_cyc == esc_at);
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst && bus.pix_valid && bus.pix_ready) begin
      if (sb.size() == 0) chk("unexpected_pixel", 1, 0);
      else begin
        pix_t e;
        e = sb.pop_front();
        chk("px", int'(bus.px), e.px);
        chk("py", int'(bus.py), e.py);
        chk("pn", int'(bus.pn), e.pn);
      end
    end
  end

  task automatic push_frame(int m, int en, int ex, int ey, int eat, int upto);
    for (int y = 0; y < YRES; y++)
      for (int x = 0; x < XRES; x++) begin
        pix_t p;
        p.px = x;
        p.py = y;
        p.pn = (en != 0 && x == ex && y == ey && eat - 1 < m) ? eat - 1 : m;
        if (y * XRES + x < upto) sb.push_back(p);
      end
  endtask

  // start is accepted at the next posedge; returns with the INIT cycle current
  task automatic do_start(int m);
    tick();
    bus.start = 1'b1;
    bus.max_iter = 8'(m);
    tick();
    bus.start = 1'b0;
    bus.max_iter = 8'(m) ^ 8'hA5;
  endtask

  task automatic wait_done(int exp_cyc);
    int cnt = 1;
    while (!bus.done && cnt < 5000) begin
      tick();
      if (!bus.done) cnt++;
    end
    if (exp_cyc >= 0) chk("frame_cycles", cnt, exp_cyc);
    chk("done", int'(bus.done), 1);
    chk("busy_after_frame", int'(bus.busy), 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic run_frame(frame_t f);
    esc_en = f.esc_en; esc_x = f.ex; esc_y = f.ey; esc_at = f.eat;
    push_frame(f.max, f.esc_en, f.ex, f.ey, f.eat, XRES * YRES);
    do_start(f.max);
    wait_done(f.cyc);
    esc_en = 0;
  endtask

  initial begin
    int cnt;
    // cycles INIT..NEXTROW = 1 + YRES*(2 + XRES*(max+3)), less skipped ITER cycles on escape
    tbl[0] = '{max: 3,   esc_en: 0, ex: 0, ey: 0, eat: 0, cyc: 53};
    tbl[1] = '{max: 3,   esc_en: 1, ex: 1, ey: 0, eat: 2, cyc: 51};
    tbl[2] = '{max: 0,   esc_en: 0, ex: 0, ey: 0, eat: 0, cyc: 29};
    tbl[3] = '{max: 5,   esc_en: 1, ex: 3, ey: 1, eat: 1, cyc: 64};
    tbl[4] = '{max: 255, esc_en: 0, ex: 0, ey: 0, eat: 0, cyc: 2069};

    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.max_iter = '0; bus.pix_ready = 1'b1;
    tick(); tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_valid", int'(bus.pix_valid), 0);
    chk("rst_px", int'(bus.px), 0);
    chk("rst_pn", int'(bus.pn), 0);
    chk("rst_inity", int'(bus.inity), 0);
    rst = 1'b0;
    tick();
    chk("idle_done", int'(bus.done), 0);

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // consumer stall on the first pixel
    bus.pix_ready = 1'b0;
    push_frame(2, 0, 0, 0, 0, XRES * YRES);
    do_start(2);
    cnt = 0;
    while (!bus.pix_valid && cnt < 100) begin tick(); cnt++; end
    chk("stall_reach_emit", int'(bus.pix_valid), 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", int'(bus.pix_valid), 1);
      chk("stall_px", int'(bus.px), 0);
      chk("stall_pn", int'(bus.pn), 2);
      chk("stall_enx", int'(bus.enx), 0);
      tick();
    end
    bus.pix_ready = 1'b1;
    #1;
    chk("release_enx", int'(bus.enx), 1);
    wait_done(-1);

    // abort in ITER of pixel (2,1)
    push_frame(3, 0, 0, 0, 0, 1 * XRES + 2);
    do_start(3);
    cnt = 0;
    while (!(bus.enab && !bus.initab && bus.px == 2 && bus.py == 1) && cnt < 200) begin tick(); cnt++; end
    chk("abort_reach_iter", int'(bus.enab), 1);
    bus.abort = 1'b1;
    #1;
    chk("abort_enab", int'(bus.enab), 0);
    chk("abort_valid", int'(bus.pix_valid), 0);
    tick();
    bus.abort = 1'b0;
    chk("abort_idle_busy", int'(bus.busy), 0);
    chk("abort_idle_done", int'(bus.done), 0);
    chk("abort_hold_px", int'(bus.px), 2);
    chk("abort_sb_empty", sb.size(), 0);
    push_frame(3, 0, 0, 0, 0, XRES * YRES);
    do_start(3);
    chk("restart_inity", int'(bus.inity), 1);
    tick();
    chk("restart_initx", int'(bus.initx), 1);
    chk("restart_py", int'(bus.py), 0);
    wait_done(-1);

    // reset while a pixel is being offered
    bus.pix_ready = 1'b0;
    do_start(3);
    cnt = 0;
    while (!bus.pix_valid && cnt < 100) begin tick(); cnt++; end
    chk("rst_reach_emit", int'(bus.pix_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(bus.pix_valid), 0);
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_pn", int'(bus.pn), 0);
    tick();
    rst = 1'b0;
    bus.pix_ready = 1'b1;

    run_frame(tbl[0]);
    run_frame(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
